// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and default parameters for the SDRAM arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        M0   = 2'd1,
        M1   = 2'd2
    } owner_t;

    localparam int DEF_ADDR_W   = 24;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_PEND = 4;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// rtl/sdram_arb_tag_fifo.sv - 1-bit read-tag FIFO recording which master owns each outstanding read
module sdram_arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic head_tag,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_tag = mem[rd_ptr];

    // Tag storage needs no reset: empty gating keeps stale entries unobservable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-master round-robin arbiter with command locking and read-tag routing
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic                s_read,
    output logic                s_write,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                err_rdv
);

    owner_t owner_q, owner_d;
    owner_t last_q, last_d;
    owner_t grant;
    logic   m0_req, m1_req;
    logic   fifo_push, fifo_head, fifo_full, fifo_empty;
    logic   rdv_hit;

    // Reads are gated on the registered fullness, so a same-cycle pop never frees a slot.
    assign m0_req = m0_write | (m0_read & ~fifo_full);
    assign m1_req = m1_write | (m1_read & ~fifo_full);

    always_comb begin
        grant = NONE;
        if (owner_q != NONE) begin
            grant = owner_q;
        end else if (m0_req && m1_req) begin
            grant = (last_q == M0) ? M1 : M0;
        end else if (m0_req) begin
            grant = M0;
        end else if (m1_req) begin
            grant = M1;
        end
    end

    always_comb begin
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (grant)
            M0: begin
                s_read         = m0_read;
                s_write        = m0_write;
                m0_waitrequest = s_waitrequest;
            end
            M1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read;
                s_write        = m1_write;
                m1_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

    // A stalled command locks ownership; acceptance releases it and updates fairness.
    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        if (grant != NONE) begin
            if (s_waitrequest) begin
                owner_d = grant;
            end else begin
                owner_d = NONE;
                last_d  = grant;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= NONE;
            last_q  <= M1;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign fifo_push = (grant != NONE) & ~s_waitrequest & s_read;

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_tag (grant == M1),
        .pop      (s_readdatavalid),
        .head_tag (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rdv_hit          = s_readdatavalid & ~fifo_empty;
    assign m0_readdatavalid = rdv_hit & ~fifo_head;
    assign m1_readdatavalid = rdv_hit & fifo_head;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_rdv <= 1'b0;
        end else if (s_readdatavalid && fifo_empty) begin
            err_rdv <= 1'b1;
        end
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, slave word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter MAX_PEND, default 4, maximum outstanding reads (power of 2, at least 2).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 mN_address  in  ADDR_W  master N command address, N in {0,1}.
REQ-008 mN_read / mN_write  in  1 each  master N command strobes; never asserted together.
REQ-009 mN_writedata  in  DATA_W  master N write data.
REQ-010 mN_byteenable  in  DATA_W/8  master N byte lanes.
REQ-011 mN_waitrequest  out  1  command not accepted this cycle.
REQ-012 mN_readdata  out  DATA_W  read data, equal to s_readdata for both masters.
REQ-013 mN_readdatavalid  out  1  read data belongs to master N.
REQ-014 s_address, s_writedata, s_byteenable, s_read, s_write  out  slave command from the granted master.
REQ-015 s_waitrequest  in  1  slave stall.
REQ-016 s_readdata  in  DATA_W  slave read data.
REQ-017 s_readdatavalid  in  1  slave read data valid.
REQ-018 err_rdv  out  1  sticky flag: readdatavalid arrived with no read outstanding.

Function
REQ-019 Owner register SHALL hold one of NONE, M0 or M1; last register SHALL hold M0 or M1.
REQ-020 Current grant: if owner is not NONE, grant = owner; else the single requester; if both request, the master other than last; if neither requests, no grant.
REQ-021 A master requests when read or write is high; a read SHALL count as a request only if the pending count is below MAX_PEND.
REQ-022 Granted master's address, writedata, byteenable, read and write SHALL drive the slave combinationally (zero latency); with no grant, s_read and s_write SHALL be 0.
REQ-023 Granted mN_waitrequest SHALL equal s_waitrequest; a master that is not granted SHALL see waitrequest = 1.
REQ-024 If s_waitrequest = 1 with a grant, owner SHALL become the grant, locking the command until it is accepted.
REQ-025 If s_waitrequest = 0 with a grant, the command is accepted: owner becomes NONE and last becomes the grant.
REQ-026 An accepted read SHALL push the grant ID into the tag FIFO.
REQ-027 s_readdatavalid SHALL pop the FIFO head, assert that master's readdatavalid in the same cycle, and hold the other master's readdatavalid at 0.
REQ-028 Push and pop in the same cycle SHALL leave the count unchanged.
REQ-029 Full gating SHALL use the registered count and ignore a same-cycle pop.
REQ-030 At full, a pending read SHALL see waitrequest = 1, while writes and the other master still arbitrate.
REQ-031 s_readdatavalid with an empty FIFO SHALL set err_rdv, assert no mN_readdatavalid, and leave the count at 0.
REQ-032 FIFO pointers SHALL wrap modulo MAX_PEND.
REQ-033 Once owner is locked, the other master's request SHALL NOT preempt it.

Reset
REQ-034 Asserting reset_n low SHALL immediately set owner = NONE, last = M1 (M0 gets first priority), FIFO empty, count = 0 and err_rdv = 0.
REQ-035 Reset mid-operation SHALL drop outstanding read tags; later stray readdatavalid SHALL set err_rdv.

Structure
REQ-036 Package sdram_arb_pkg SHALL hold owner_t (NONE, M0, M1) and default parameter constants.
REQ-037 Sub-module sdram_arb_tag_fifo SHALL implement the 1-bit-wide, MAX_PEND-deep tag FIFO with count, full and empty.

Verification
REQ-038 Both masters read with s_waitrequest = 0 after reset -> M0 granted first, M1 next cycle; s_readdatavalid twice -> m0_readdatavalid, then m1_readdatavalid.
REQ-039 M0 writes 0x1234 to address 0x10 while s_waitrequest = 1 for 3 cycles, and M1 requests meanwhile -> s_address stays 0x10 for all 4 cycles; M1 granted on cycle 5.
REQ-040 M0 issues 4 reads with no readdatavalid returned -> 5th read stalls; an M1 write is still accepted.
REQ-041 At count = 4, a pop and M0 read occur in the same cycle -> read stalls that cycle and is accepted the next.
REQ-042 s_readdatavalid with empty FIFO -> err_rdv = 1 until reset_n is low; both mN_readdatavalid stay 0.
REQ-043 Reset asserted with 2 reads pending -> count = 0, owner = NONE; next simultaneous request grants M0.
